// File: rtl/reg_file_sb_if.sv
// ID register-read/issue channel and WB write channel of the register file.
// The register file holds the slave modport; the ID/WB stages drive through master.
interface reg_file_sb_if #(
    parameter int DATA_W = 32
);
    logic [4:0]        i_ID_reg_RegAddr1;
    logic [4:0]        i_ID_reg_RegAddr2;
    logic [DATA_W-1:0] o_ID_reg_RegData1;
    logic [DATA_W-1:0] o_ID_reg_RegData2;
    logic              i_ID_ctrl_UseRS;
    logic              i_ID_ctrl_UseRT;
    logic              i_ID_ctrl_Issue;
    logic              i_ID_ctrl_RegWrite;
    logic [4:0]        i_ID_data_DestAddr;
    logic              o_ID_ctrl_Stall;
    logic              i_WB_reg_RegWrite;
    logic [4:0]        i_WB_reg_WriteAddr;
    logic [DATA_W-1:0] i_WB_reg_WriteData;

    modport slave (
        input  i_ID_reg_RegAddr1, i_ID_reg_RegAddr2,
        input  i_ID_ctrl_UseRS, i_ID_ctrl_UseRT, i_ID_ctrl_Issue,
        input  i_ID_ctrl_RegWrite, i_ID_data_DestAddr,
        input  i_WB_reg_RegWrite, i_WB_reg_WriteAddr, i_WB_reg_WriteData,
        output o_ID_reg_RegData1, o_ID_reg_RegData2, o_ID_ctrl_Stall
    );

    modport master (
        output i_ID_reg_RegAddr1, i_ID_reg_RegAddr2,
        output i_ID_ctrl_UseRS, i_ID_ctrl_UseRT, i_ID_ctrl_Issue,
        output i_ID_ctrl_RegWrite, i_ID_data_DestAddr,
        output i_WB_reg_RegWrite, i_WB_reg_WriteAddr, i_WB_reg_WriteData,
        input  o_ID_reg_RegData1, o_ID_reg_RegData2, o_ID_ctrl_Stall
    );
endinterface

// File: rtl/reg_file_sb.sv
// 32x32 MIPS register file with a per-register pending-write scoreboard that
// stalls ID while a source register still has an outstanding writeback.
module reg_file_sb #(
    parameter int DATA_W        = 32,
    parameter int CNT_W         = 2,
    parameter bit WRITE_THROUGH = 1'b1
) (
    input  logic          clk,
    input  logic          nrst,
    reg_file_sb_if.slave  rf,
    output logic          o_err
);
    logic [DATA_W-1:0] regs_reg [0:31];
    logic [31:0]       wbhit;
    logic [31:0]       busy_vec;
    logic [31:0]       fault_vec;
    logic              accept;
    logic              err_reg;

    assign wbhit[0]     = 1'b0;
    assign busy_vec[0]  = 1'b0;
    assign fault_vec[0] = 1'b0;

    // Stall only looks at sources the ID instruction actually uses.
    assign rf.o_ID_ctrl_Stall = rf.i_ID_ctrl_Issue &&
        ((rf.i_ID_ctrl_UseRS && busy_vec[rf.i_ID_reg_RegAddr1]) ||
         (rf.i_ID_ctrl_UseRT && busy_vec[rf.i_ID_reg_RegAddr2]));

    assign accept = rf.i_ID_ctrl_Issue && !rf.o_ID_ctrl_Stall &&
                    rf.i_ID_ctrl_RegWrite && (rf.i_ID_data_DestAddr != 5'd0);

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_pend
            logic [CNT_W-1:0] pend_reg;
            logic             inc;
            logic             dec;

            assign wbhit[gi] = rf.i_WB_reg_RegWrite && (rf.i_WB_reg_WriteAddr == 5'(gi));
            assign inc       = accept && (rf.i_ID_data_DestAddr == 5'(gi));
            assign dec       = wbhit[gi];

            // A writeback this cycle retires one pending write before the busy test.
            if (WRITE_THROUGH) begin : g_wt
                assign busy_vec[gi] = (pend_reg - CNT_W'(wbhit[gi])) != '0;
            end else begin : g_nwt
                assign busy_vec[gi] = pend_reg != '0;
            end

            assign fault_vec[gi] = (inc && !dec && (&pend_reg)) ||
                                   (dec && !inc && (pend_reg == '0));

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    pend_reg <= '0;
                end else if (inc && !dec) begin
                    if (!(&pend_reg))
                        pend_reg <= pend_reg + 1'b1;
                end else if (dec && !inc) begin
                    if (pend_reg != '0)
                        pend_reg <= pend_reg - 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 32; i++)
                regs_reg[i] <= '0;
        end else if (rf.i_WB_reg_RegWrite && (rf.i_WB_reg_WriteAddr != 5'd0)) begin
            regs_reg[rf.i_WB_reg_WriteAddr] <= rf.i_WB_reg_WriteData;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            err_reg <= 1'b0;
        else if (|fault_vec)
            err_reg <= 1'b1;
    end

    assign o_err = err_reg;

    always_comb begin
        rf.o_ID_reg_RegData1 = '0;
        if (rf.i_ID_reg_RegAddr1 != 5'd0) begin
            if (WRITE_THROUGH && wbhit[rf.i_ID_reg_RegAddr1])
                rf.o_ID_reg_RegData1 = rf.i_WB_reg_WriteData;
            else
                rf.o_ID_reg_RegData1 = regs_reg[rf.i_ID_reg_RegAddr1];
        end
    end

    always_comb begin
        rf.o_ID_reg_RegData2 = '0;
        if (rf.i_ID_reg_RegAddr2 != 5'd0) begin
            if (WRITE_THROUGH && wbhit[rf.i_ID_reg_RegAddr2])
                rf.o_ID_reg_RegData2 = rf.i_WB_reg_WriteData;
            else
                rf.o_ID_reg_RegData2 = regs_reg[rf.i_ID_reg_RegAddr2];
        end
    end
endmodule
